// File: rtl/qsys_pio_pkg.sv
// Shared constants for the PIO key block: Avalon-MM word addresses and a
// helper that sizes the per-bit debounce counters.
package qsys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned BUS_WIDTH = 32;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qsys_pio_debounce.sv
// One key bit: 2-flop synchronizer followed, when QSYS_PIO_KEY_DEBOUNCE_EN is
// defined, by a stability counter; otherwise the synchronizer output is the filtered value.
module qsys_pio_debounce
  import qsys_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic pin_i,
  output logic filtered_o
);

  logic meta_q;
  logic sync_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("qsys_pio_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  // Keys idle high, so reset to ones to avoid a phantom fall on release.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
    end
  end

`ifdef QSYS_PIO_KEY_DEBOUNCE_EN
  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          filt_q;
  logic          filt_d;

  // The counter runs only while the synchronized pin disagrees with the
  // filtered value; any return to agreement restarts the stability window.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      filt_d = sync_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filtered_o = filt_q;
`else
  assign filtered_o = sync_q;
`endif

endmodule

// File: rtl/qsys_pio_key.sv
// Avalon-MM key PIO: synchronized/filtered inputs, falling-edge capture with
// write-1-to-clear, maskable level irq. Debounce enabled by QSYS_PIO_KEY_DEBOUNCE_EN.
module qsys_pio_key
  import qsys_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] cap_clr;
  logic             irq_q;
  logic             irq_d;
  logic             wr_en;
  logic             mask_wr;
  logic             cap_wr;

  assign wr_en   = chipselect & ~write_n;
  assign mask_wr = wr_en && (address == ADDR_IRQMASK);
  assign cap_wr  = wr_en && (address == ADDR_EDGECAP);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    qsys_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .pin_i     (in_port[gi]),
      .filtered_o(filtered[gi])
    );

    assign fall_d[gi]  = prev_q[gi] & ~filtered[gi];
    assign cap_clr[gi] = cap_wr & writedata[gi];
    // A registered fall always wins over a same-cycle clear.
    assign cap_d[gi]   = fall_q[gi] | (cap_q[gi] & ~cap_clr[gi]);
  end

  if (WIDTH < BUS_WIDTH) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[BUS_WIDTH-1:WIDTH]};
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_wr) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  assign irq_d = |(cap_q & mask_q);

  // Pipeline: prev captures the filtered value, fall registers the detect,
  // cap latches it the following edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= '1;
      fall_q <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= filtered;
      fall_q <= fall_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = filtered;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
